// File: rtl/seg_disp_ctrl_pkg.sv
// seg_pkg: shared constants and types for the six-digit seven-segment controller.
//   NUM_DIGITS - number of display digits
//   SEG_BLANK  - active-low pattern with every segment and the dot off
//   SEG_TABLE  - active-low hex glyphs, bit 7 = a ... bit 1 = g, bit 0 = dp (off)
//   disp_state_t - display FSM state
package seg_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Entry n is the glyph for nibble n (entry 0 is the rightmost byte).
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
      8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
   };

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } disp_state_t;

endpackage

// File: rtl/seg_disp_ctrl_if.sv
// seg_disp_if: the two valid/ready write ports sharing the display.
//   req0_* - CPU MMIO store path
//   req1_* - keyboard scan-code path
//   valid/data/wmask are driven by the requester, ready by the controller.
interface seg_disp_if;

   logic        req0_valid;
   logic        req0_ready;
   logic [23:0] req0_data;
   logic [5:0]  req0_wmask;

   logic        req1_valid;
   logic        req1_ready;
   logic [23:0] req1_data;
   logic [5:0]  req1_wmask;

   modport master (
      output req0_valid, req0_data, req0_wmask,
      output req1_valid, req1_data, req1_wmask,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_data, req0_wmask,
      input  req1_valid, req1_data, req1_wmask,
      output req0_ready, req1_ready
   );

endinterface

// File: rtl/seg_disp_ctrl_hex_enc.sv
// seg_hex_enc: combinational hex nibble to active-low seven-segment glyph.
//   i_nib - hex value 0..F
//   o_seg - active-low pattern, decimal point off
module seg_hex_enc
   import seg_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [7:0] o_seg
);

   assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: arbitrated six-digit seven-segment display controller.
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   disp_en     - global enable; 0 forces every digit blank
//   req         - two valid/ready write ports (seg_disp_if.slave)
//   seg0..5_output - registered active-low digit patterns
//
// state | meaning
// BLANK | all digits dark; waiting for any accepted write or keep-alive
// SHOW  | enabled digits lit; idle counter running toward the timeout
module seg_disp_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       disp_en,
   seg_disp_if.slave  req,
   output logic [7:0] seg0_output,
   output logic [7:0] seg1_output,
   output logic [7:0] seg2_output,
   output logic [7:0] seg3_output,
   output logic [7:0] seg4_output,
   output logic [7:0] seg5_output
);

   localparam int CNT_W = (IDLE_CYCLES == 0) ? 1 : $clog2(IDLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (IDLE_CYCLES == 0) ? '0 : CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   disp_state_t                      r_state, w_state_nxt;
   logic [CNT_W-1:0]                 r_idle_cnt, w_cnt_nxt;
   logic [23:0]                      r_val, w_val_nxt;
   logic [NUM_DIGITS-1:0]            r_dig_on, w_dig_nxt;
   logic                             r_rr_ptr, w_rr_nxt;
   logic [NUM_DIGITS-1:0][7:0]       r_seg;
   logic [NUM_DIGITS-1:0][7:0]       w_enc;

   logic        w_gnt0, w_gnt1, w_accept;
   logic [23:0] w_wdata;
   logic [5:0]  w_wmask;

   // r_rr_ptr names the requester that wins a tie; reset masks both grants.
   assign w_gnt0   = !rst && req.req0_valid && (!req.req1_valid || !r_rr_ptr);
   assign w_gnt1   = !rst && req.req1_valid && (!req.req0_valid ||  r_rr_ptr);
   assign w_accept = w_gnt0 || w_gnt1;

   assign req.req0_ready = w_gnt0;
   assign req.req1_ready = w_gnt1;

   assign w_rr_nxt = w_gnt0 ? 1'b1 : (w_gnt1 ? 1'b0 : r_rr_ptr);

   always_comb begin
      w_wdata   = w_gnt1 ? req.req1_data  : req.req0_data;
      w_wmask   = w_gnt1 ? req.req1_wmask : req.req0_wmask;
      w_val_nxt = r_val;
      w_dig_nxt = r_dig_on;
      if (w_accept) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_wmask[i]) begin
               w_val_nxt[4*i +: 4] = w_wdata[4*i +: 4];
               w_dig_nxt[i]        = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_idle_cnt;
      case (r_state)
         BLANK: begin
            if (w_accept) begin
               w_state_nxt = SHOW;
               w_cnt_nxt   = '0;
            end
         end
         SHOW: begin
            // An accept in the expiry cycle keeps the display up.
            if (w_accept) begin
               w_cnt_nxt = '0;
            end else if (IDLE_CYCLES != 0 && r_idle_cnt == CNT_LAST) begin
               w_state_nxt = BLANK;
               w_cnt_nxt   = '0;
            end else if (r_idle_cnt != CNT_MAX) begin
               w_cnt_nxt = r_idle_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= BLANK;
         r_idle_cnt <= '0;
         r_val      <= '0;
         r_dig_on   <= '0;
         r_rr_ptr   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idle_cnt <= w_cnt_nxt;
         r_val      <= w_val_nxt;
         r_dig_on   <= w_dig_nxt;
         r_rr_ptr   <= w_rr_nxt;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
      seg_hex_enc u_enc (
         .i_nib (r_val[4*g +: 4]),
         .o_seg (w_enc[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_seg[i] <= (disp_en && r_state == SHOW && r_dig_on[i]) ? w_enc[i] : SEG_BLANK;
         end
      end
   end

   assign seg0_output = r_seg[0];
   assign seg1_output = r_seg[1];
   assign seg2_output = r_seg[2];
   assign seg3_output = r_seg[3];
   assign seg4_output = r_seg[4];
   assign seg5_output = r_seg[5];

endmodule
